note_player: RTL and testbench

NOTE_PLAYER -- requirements
Module: note_player

---
 rtl/note_pkg.sv | 37 +++
 rtl/note_inc_lut.sv | 19 +
 rtl/note_player.sv | 142 ++++++++++++++
 tb/tb_note_player.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/note_pkg.sv
// Shared types, widths and the note-to-increment helper for the note player.
package note_pkg;

  localparam int unsigned PHASE_W  = 24;
  localparam int unsigned NOTE_W   = 6;
  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned DUR_W    = 8;
  localparam int unsigned REM_W    = 22;
  localparam int unsigned FS_HZ    = 48000;
  localparam int unsigned NOTE_CNT = 1 << NOTE_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PLAY,
    ST_GAP
  } state_e;

  // Note word as latched on accept
  typedef struct packed {
    logic [NOTE_W-1:0] key;
    logic [DUR_W-1:0]  beats;
  } note_word_t;

  // Equal-tempered phase increment, rounded; key 0 is a rest
  function automatic logic [PHASE_W-1:0] note_inc(input int unsigned key);
    real freq;
    real inc;
    if (key == 0) begin
      return '0;
    end
    freq = 440.0 * (2.0 ** ((real'(key) - 49.0) / 12.0));
    inc  = freq * real'(64'(1) << PHASE_W) / real'(FS_HZ);
    return PHASE_W'($rtoi(inc + 0.5));
  endfunction

endpackage

// File: rtl/note_inc_lut.sv
// Combinational 64-entry table: piano key number -> 24-bit phase increment.
module note_inc_lut
  import note_pkg::*;
(
  input  logic [NOTE_W-1:0]  note,
  output logic [PHASE_W-1:0] inc_c
);

  logic [PHASE_W-1:0] inc_tbl [NOTE_CNT];

  // Table contents are fixed at elaboration
  for (genvar i = 0; i < NOTE_CNT; i++) begin : g_tbl
    localparam logic [PHASE_W-1:0] INC = note_inc(i);
    assign inc_tbl[i] = INC;
  end

  assign inc_c = inc_tbl[note];

endmodule

// File: rtl/note_player.sv
// Square-wave note player: accepts (note, duration) words, produces one audio
// sample per sample tick, with an optional silent tail per note.
// Build option: define NOTE_PLAYER_GAP_EN to enable the silent GAP tail.
module note_player
  import note_pkg::*;
#(
  parameter int unsigned                SAMPLE_DIV   = 2083,
  parameter int unsigned                BEAT_SAMPLES = 6000,
  parameter int unsigned                GAP_SAMPLES  = 480,
  parameter logic signed [SAMPLE_W-1:0] AMP          = 16'sd8192
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       note_valid,
  input  logic [NOTE_W-1:0]          note,
  input  logic [DUR_W-1:0]           duration,
  output logic                       note_ready,
  output logic signed [SAMPLE_W-1:0] sample_out,
  output logic                       sample_valid,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

`ifdef NOTE_PLAYER_GAP_EN
  localparam logic [REM_W-1:0] GAP_TGT = REM_W'(GAP_SAMPLES);
`else
  // Gap length has no effect in this build; notes play to the last tick
  localparam logic [REM_W-1:0] GAP_TGT = REM_W'(GAP_SAMPLES * 0);
`endif

  logic [CNT_W-1:0]           div_cnt;
  logic                       tick_c;
  state_e                     state;
  note_word_t                 cur;
  logic [PHASE_W-1:0]         phase;
  logic [PHASE_W-1:0]         inc_q;
  logic [PHASE_W-1:0]         lut_inc_c;
  logic [REM_W-1:0]           remain;
  logic [REM_W-1:0]           rem_dec_c;
  logic [REM_W-1:0]           load_ticks_c;
  logic                       accept_c;
  logic signed [SAMPLE_W-1:0] tone_c;

  note_inc_lut u_lut (
    .note  (cur.key),
    .inc_c (lut_inc_c)
  );

  assign tick_c       = (div_cnt == CNT_W'(SAMPLE_DIV - 1));
  assign accept_c     = note_valid && note_ready;
  assign rem_dec_c    = remain - REM_W'(1);
  assign load_ticks_c = REM_W'(cur.beats) * REM_W'(BEAT_SAMPLES);
  assign tone_c       = (cur.key == '0) ? '0 :
                        (phase[PHASE_W-1] ? SAMPLE_W'(-AMP) : AMP);

  // Free-running sample-rate divider; sample_valid marks each tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt      <= '0;
      sample_valid <= 1'b0;
    end else begin
      div_cnt      <= tick_c ? '0 : div_cnt + CNT_W'(1);
      sample_valid <= tick_c;
    end
  end

  // Note sequencer: IDLE -> LOAD -> PLAY -> (GAP) -> IDLE, with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cur        <= '0;
      phase      <= '0;
      inc_q      <= '0;
      remain     <= '0;
      sample_out <= '0;
      note_ready <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (tick_c) begin
        sample_out <= '0;
      end
      case (state)
        ST_IDLE: begin
          if (accept_c) begin
            cur   <= '{key: note, beats: duration};
            phase <= '0;
            if (duration == '0) begin
              done <= 1'b1;
            end else begin
              state      <= ST_LOAD;
              note_ready <= 1'b0;
              busy       <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          inc_q  <= lut_inc_c;
          remain <= load_ticks_c;
          state  <= (load_ticks_c <= GAP_TGT) ? ST_GAP : ST_PLAY;
        end
        ST_PLAY: begin
          if (tick_c) begin
            sample_out <= tone_c;
            phase      <= phase + inc_q;
            remain     <= rem_dec_c;
            if (rem_dec_c == GAP_TGT) begin
              if (GAP_TGT == '0) begin
                state      <= ST_IDLE;
                note_ready <= 1'b1;
                busy       <= 1'b0;
                done       <= 1'b1;
              end else begin
                state <= ST_GAP;
              end
            end
          end
        end
        ST_GAP: begin
          if (tick_c) begin
            remain <= rem_dec_c;
            if (remain <= REM_W'(1)) begin
              state      <= ST_IDLE;
              note_ready <= 1'b1;
              busy       <= 1'b0;
              done       <= 1'b1;
            end
          end
        end
        default: begin
          state      <= ST_IDLE;
          note_ready <= 1'b1;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_note_player.sv
// Self-checking bench for note_player against a tick-level behavioural model.
module tb_note_player;

  localparam int unsigned SDIV = 4;
  localparam int unsigned BEAT = 8;
  localparam int unsigned GAP  = 2;
  localparam longint      AMPV = 8192;
`ifdef NOTE_PLAYER_GAP_EN
  localparam int GAP_EFF = GAP;
`else
  localparam int GAP_EFF = 0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              note_valid = 1'b0;
  logic [5:0]        note = '0;
  logic [7:0]        duration = '0;
  logic              note_ready;
  logic signed [15:0] sample_out;
  logic              sample_valid;
  logic              busy;
  logic              done;

  note_player #(
    .SAMPLE_DIV   (SDIV),
    .BEAT_SAMPLES (BEAT),
    .GAP_SAMPLES  (GAP),
    .AMP          (16'sd8192)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .note_valid   (note_valid),
    .note         (note),
    .duration     (duration),
    .note_ready   (note_ready),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Spec formula: round(f * 2^24 / 48000), f = 440 * 2^((n-49)/12)
  function automatic longint model_inc(input int n);
    real f;
    if (n == 0) return 0;
    f = 440.0 * (2.0 ** ((real'(n) - 49.0) / 12.0));
    return longint'($rtoi(f * 16777216.0 / 48000.0 + 0.5));
  endfunction

  // Sample number idx of a note: sign from the accumulated phase before that tick
  function automatic longint model_tone(input int n, input longint inc, input longint idx);
    longint ph;
    if (n == 0) return 0;
    ph = (idx * inc) % 16777216;
    return (ph >= 8388608) ? -AMPV : AMPV;
  endfunction

  // Behavioural model state
  int     k;
  bit     m_active;
  int     m_start, m_total, m_play, m_ticks, m_note;
  longint m_inc;
  bit     e_ready = 1'b1, e_busy, e_done, e_valid;
  longint e_sample;
  bit     acc, tick_e;
  longint val;
  bit     chk_en = 1'b0;

  // Model: edge k is a tick when k is a multiple of SDIV; a note's ticks start two edges after accept
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k = 0; m_active = 0; e_ready = 1; e_busy = 0; e_done = 0; e_valid = 0; e_sample = 0;
    end else begin
      acc = note_valid && e_ready;
      k++;
      tick_e = (k % SDIV) == 0;
      e_done = 0;
      e_valid = tick_e;
      if (tick_e) begin
        val = 0;
        if (m_active && k >= m_start + 2) begin
          if (m_ticks < m_play) val = model_tone(m_note, m_inc, m_ticks);
          m_ticks++;
          if (m_ticks == m_total) begin
            m_active = 0;
            e_done = 1;
          end
        end
        e_sample = val;
      end
      if (acc) begin
        if (duration == 0) begin
          e_done = 1;
        end else begin
          m_active = 1;
          m_start  = k;
          m_total  = int'(duration) * BEAT;
          m_play   = (m_total > GAP_EFF) ? m_total - GAP_EFF : 0;
          m_ticks  = 0;
          m_note   = int'(note);
          m_inc    = model_inc(int'(note));
        end
      end
      e_ready = !m_active;
      e_busy  = m_active;
    end
  end

  // Compare every cycle while out of reset
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      check("sample_valid", longint'(sample_valid), longint'(e_valid));
      check("sample_out", longint'(sample_out), e_sample);
      check("note_ready", longint'(note_ready), longint'(e_ready));
      check("busy", longint'(busy), longint'(e_busy));
      check("done", longint'(done), longint'(e_done));
    end
  end

  // Capture of note samples and done pulses for directed literal checks
  longint cap[$];
  int     dcnt;
  always @(negedge clk) begin
    if (rst_n) begin
      if (sample_valid && (busy || done)) cap.push_back(longint'(sample_out));
      if (done) dcnt++;
    end
  end

  task automatic send(input int n, input int d, output bit with_done);
    int guard;
    note = 6'(n);
    duration = 8'(d);
    note_valid = 1'b1;
    guard = 0;
    while (!note_ready && guard < 4000) begin
      @(negedge clk); #1;
      guard++;
    end
    if (guard >= 4000) check("accept_timeout", 0, 1);
    with_done = done;
    @(negedge clk); #1;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (busy && guard < 4000) begin
      @(negedge clk); #1;
      guard++;
    end
    if (guard >= 4000) check("idle_timeout", 0, 1);
    @(negedge clk); #1;
  endtask

  function automatic int count_val(input longint v);
    int c;
    c = 0;
    foreach (cap[i]) if (cap[i] == v) c++;
    return c;
  endfunction

  initial begin
    bit wd;
    int npos;
    // Pin the model against hand-computed values
    check("pin_inc49", model_inc(49), 153791);
    check("pin_inc0", model_inc(0), 0);
    check("pin_inc61", model_inc(61), 307582);
    check("pin_tone54", model_tone(49, 153791, 54), 8192);
    check("pin_tone55", model_tone(49, 153791, 55), -8192);

    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    rst_n = 1'b1;
    #1;
    cap.delete();
    dcnt = 0;
    check("rst_ready", longint'(note_ready), 1);
    check("rst_busy", longint'(busy), 0);
    check("rst_sample", longint'(sample_out), 0);
    repeat (12) @(negedge clk);
    #1;
    check("tick_count_12cyc", cap.size(), 0);
    check("idle_done_none", dcnt, 0);

    // A4, one beat
    cap.delete(); dcnt = 0;
    send(49, 1, wd);
    note_valid = 1'b0;
    wait_idle();
    npos = count_val(AMPV);
`ifdef NOTE_PLAYER_GAP_EN
    check("a4_pos_ticks", npos, 6);
    check("a4_gap_last", cap[cap.size()-1], 0);
    check("a4_gap_prev", cap[cap.size()-2], 0);
`else
    check("a4_pos_ticks", npos, 8);
    check("a4_last_tick", cap[cap.size()-1], AMPV);
`endif
    check("a4_neg_ticks", count_val(-AMPV), 0);
    check("a4_done_cnt", dcnt, 1);

    // Rest, two beats
    cap.delete(); dcnt = 0;
    send(0, 2, wd);
    note_valid = 1'b0;
    wait_idle();
    check("rest_zero_ticks", longint'(count_val(0) == cap.size()), 1);
    check("rest_tick_span", longint'(cap.size() == 16 || cap.size() == 17), 1);
    check("rest_done_cnt", dcnt, 1);

    // Zero duration
    dcnt = 0;
    send(12, 0, wd);
    note_valid = 1'b0;
    check("dur0_done", longint'(done), 1);
    check("dur0_ready", longint'(note_ready), 1);
    check("dur0_busy", longint'(busy), 0);
    @(negedge clk); #1;
    check("dur0_done_once", longint'(done), 0);

    // Back-to-back with valid held
    cap.delete(); dcnt = 0;
    send(49, 1, wd);
    send(52, 1, wd);
    note_valid = 1'b0;
    check("b2b_accept_in_done", longint'(wd), 1);
    wait_idle();
    check("b2b_done_cnt", dcnt, 2);

    // Reset during PLAY
    send(49, 4, wd);
    note_valid = 1'b0;
    repeat (40) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_sample", longint'(sample_out), 0);
    check("rstmid_busy", longint'(busy), 0);
    check("rstmid_done", longint'(done), 0);
    check("rstmid_ready", longint'(note_ready), 1);
    check("rstmid_valid", longint'(sample_valid), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    dcnt = 0;
    repeat (40) @(negedge clk);
    #1;
    check("rstmid_no_done", dcnt, 0);

    // Randomized note stream
    for (int i = 0; i < 40; i++) begin
      int n, d;
      n = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 63));
      d = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 14));
      send(n, d, wd);
      if ($urandom_range(0, 2) != 0) begin
        note_valid = 1'b0;
        repeat ($urandom_range(0, 7)) begin
          note = 6'($urandom);
          duration = 8'($urandom);
          @(negedge clk); #1;
        end
      end
    end
    note_valid = 1'b0;
    wait_idle();
    repeat (8) @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #900000;
    miscompares++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog expired");
  end

endmodule
